chunked_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It takes two WIDTH-bit operands over a valid/ready handshake and processes them CHUNK bits per clock, least-significant chunk first, carrying the carry between chunks in a register. It returns sum, carry-out and signed overflow over a second valid/ready handshake. It is the sequential, width-generic successor to the team's single-bit combinational half/full adder cells, sized for datapaths where a full-width carry chain would not close timing.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/chunk_add.sv | 28 ++
 rtl/chunked_adder.sv | 131 +++++++++++++
 tb/tb_chunked_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder datapath.
//   state_e    : control states of the chunked adder FSM
//   clog2_min1 : ceil(log2(n)) clamped to at least one bit, for counter sizing
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest w >= 1 with 2**w >= n.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice.
//   a, b  : chunk operands
//   ci    : carry into bit 0
//   s     : chunk sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (signed-overflow detection)
module chunk_add #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  // Carry into the MSB is recovered from the MSB sum bit, which also covers CHUNK == 1.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(ci);
    s     = full[CHUNK-1:0];
    co    = full[CHUNK];
    c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock, LSB chunk first.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sub = 1 computes a - b (cin ignored); cout = 1 means no borrow
module chunked_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int unsigned NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int unsigned CNT_W      = clog2_min1(NCHUNK);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_param
      $error("chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   ch_s;
  logic               ch_co;
  logic               ch_cmsb;

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_cmsb)
  );

  // Handshake flags decode straight from state; in_ready is masked during reset.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // New chunk enters sum at the top; after NCHUNK shifts it is fully aligned.
        sum_d                    = sum_q >> CHUNK;
        sum_d[WIDTH-1 -: CHUNK]  = ch_s;
        a_d                      = a_q >> CHUNK;
        b_d                      = b_q >> CHUNK;
        carry_d                  = ch_co;
        cnt_d                    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = ch_co;
          ovf_d   = ch_cmsb ^ ch_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: three instances (CHUNK = 8, 32, 4) share operands.
module tb_chunked_adder;

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic        out_ready;
  logic [31:0] op_a, op_b;
  logic        op_cin, op_sub;
  logic [31:0] sum_w [3];
  logic [2:0]  cout_w;
  logic [2:0]  ovf_w;

  int checks;
  int errors;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(op_a), .b(op_b), .cin(op_cin), .sub(op_sub),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  chunked_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(op_a), .b(op_b), .cin(op_cin), .sub(op_sub),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  chunked_adder #(.WIDTH(32), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(op_a), .b(op_b), .cin(op_cin), .sub(op_sub),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on unit u; returns result and cycles from accept to out_valid.
  task automatic do_op(input int u, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tcin, input logic tsub,
                       output logic [31:0] rs, output logic rc, output logic ro,
                       output int lat);
    int guard;
    op_a = ta; op_b = tb_v; op_cin = tcin; op_sub = tsub;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready[u] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 64'(0), 64'(1));
    in_valid[u] = 1'b1;
    @(negedge clk);
    in_valid[u] = 1'b0;
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rs = sum_w[u];
    rc = cout_w[u];
    ro = ovf_w[u];
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] rs;
  logic        rc, ro;
  int          lat;
  int          seen;
  logic [32:0] ref_full;
  logic [31:0] ref_s;
  logic        ref_ovf;
  logic [31:0] ra, rb;
  logic        rsub, rcin;

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    checks = 0; errors = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum_w[0]), 64'(0));
    check("rst_cout_ovf", 64'({cout_w[0], ovf_w[0]}), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(3'b111));
    @(negedge clk);

    // Directed vectors on CHUNK=8
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("wrap_sum", 64'(rs), 64'(32'h0));
    check("wrap_cout", 64'(rc), 64'(1));
    check("wrap_ovf", 64'(ro), 64'(0));
    check("wrap_lat", 64'(lat), 64'(4));

    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("ovf_sum", 64'(rs), 64'(32'h8000_0000));
    check("ovf_cout", 64'(rc), 64'(0));
    check("ovf_ovf", 64'(ro), 64'(1));

    do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("chunk_carry_sum", 64'(rs), 64'(32'h0000_0100));
    check("chunk_carry_flags", 64'({rc, ro}), 64'(0));

    do_op(0, 32'd5, 32'd7, 1'b1, 1'b1, rs, rc, ro, lat);
    check("sub_neg_sum", 64'(rs), 64'(32'hFFFF_FFFE));
    check("sub_neg_cout", 64'(rc), 64'(0));
    check("sub_neg_ovf", 64'(ro), 64'(0));

    do_op(0, 32'd7, 32'd5, 1'b0, 1'b1, rs, rc, ro, lat);
    check("sub_pos_sum", 64'(rs), 64'(32'd2));
    check("sub_pos_cout", 64'(rc), 64'(1));

    // Reset during the second RUN cycle aborts the operation
    op_a = 32'h0101_0101; op_b = 32'h0101_0101; op_cin = 1'b0; op_sub = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_partial_sum", 64'(sum_w[0]), 64'(32'h0200_0000));
    rst = 1'b1;
    @(negedge clk);
    check("abort_sum", 64'(sum_w[0]), 64'(0));
    check("abort_flags", 64'({cout_w[0], ovf_w[0], out_valid[0]}), 64'(0));
    check("abort_in_ready_rst", 64'(in_ready[0]), 64'(0));
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready[0]), 64'(1));
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'(0));

    // Backpressure with in_valid held high
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; op_cin = 1'b1; op_sub = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!out_valid[0] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 64'(lat), 64'(4));
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", 64'({out_valid[0], in_ready[0], cout_w[0], ovf_w[0], sum_w[0]}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h2345_678A}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", 64'({in_ready[0], out_valid[0]}), 64'(2'b10));
    @(negedge clk);
    check("bp_reaccept", 64'(in_ready[0]), 64'(0));
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp2_lat", 64'(lat), 64'(4));
    check("bp2_sum", 64'(sum_w[0]), 64'(32'h2345_678A));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Single-chunk configuration
    do_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, rs, rc, ro, lat);
    check("c32_sum", 64'(rs), 64'(0));
    check("c32_cout", 64'(rc), 64'(1));
    check("c32_ovf", 64'(ro), 64'(1));
    check("c32_lat", 64'(lat), 64'(1));

    // CHUNK=4 against a reference model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      rsub = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 32'h8000_0000; rb = 32'h0000_0001; rsub = 1'b1; end
      if (rsub) begin
        ref_full = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
        ref_s    = ref_full[31:0];
        ref_ovf  = (ra[31] != rb[31]) && (ref_s[31] != ra[31]);
      end else begin
        ref_full = {1'b0, ra} + {1'b0, rb} + 33'(rcin);
        ref_s    = ref_full[31:0];
        ref_ovf  = (ra[31] == rb[31]) && (ref_s[31] != ra[31]);
      end
      do_op(2, ra, rb, rcin, rsub, rs, rc, ro, lat);
      check("c4_result", 64'({lat[7:0], rc, ro, rs}), 64'({8'd8, ref_full[32], ref_ovf, ref_s}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
